// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//
// Multi-port register file with a per-register scoreboard ("busy" bits).
// Two write ports (A and B), two registered read ports and one reservation
// port. A reservation marks a register as pending until a later write
// delivers its value; reads of a pending register come back with rvalid low.
//
// Parameters
//   DATA_W   : register width in bits
//   ADDR_W   : address width; the file holds 2**ADDR_W registers
//   ZERO_REG : when 1, register 0 is hardwired to zero and never pending
//
// Ports
//   clk               : single clock, all state changes on its rising edge
//   rst               : synchronous, active-low reset
//   we_a / we_b       : write enables for ports A and B
//   waddr_a / waddr_b : write addresses
//   wdata_a / wdata_b : write data
//   raddr_1 / raddr_2 : read addresses, sampled at the clock edge
//   rdata_1 / rdata_2 : registered read data (one-cycle latency)
//   rvalid_1/rvalid_2 : high when the returned register is not pending
//   rsv_en / rsv_addr : reservation request and target register
//   busy              : per-register pending bits, bit i for register i
//
// Read-side qualifier: rdata_n is always driven with the register's current
// contents; rvalid_n says whether those contents are final (register not
// pending). There is no back-pressure, so no ready signal exists: a read is
// accepted every cycle and answered on the next cycle.
// ---------------------------------------------------------------------------
module register_file_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic [ADDR_W-1:0]        waddr_a,
    input  logic [ADDR_W-1:0]        waddr_b,
    input  logic [DATA_W-1:0]        wdata_a,
    input  logic [DATA_W-1:0]        wdata_b,
    input  logic [ADDR_W-1:0]        raddr_1,
    input  logic [ADDR_W-1:0]        raddr_2,
    output logic [DATA_W-1:0]        rdata_1,
    output logic [DATA_W-1:0]        rdata_2,
    output logic                     rvalid_1,
    output logic                     rvalid_2,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [(2**ADDR_W)-1:0]   busy
);

    localparam int DEPTH   = 2**ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] regs_nxt [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    logic [DEPTH-1:0]  hit_a;
    logic [DEPTH-1:0]  hit_b;
    logic [DEPTH-1:0]  hit_rsv;

    // Per-register decode of the three update sources.
    always_comb begin
        hit_a   = '0;
        hit_b   = '0;
        hit_rsv = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a[i]   = we_a   && (waddr_a  == ADDR_W'(i));
            hit_b[i]   = we_b   && (waddr_b  == ADDR_W'(i));
            hit_rsv[i] = rsv_en && (rsv_addr == ADDR_W'(i));
        end
    end

    // Next-state of the array and the scoreboard. The read ports sample
    // these next-state values, which makes reads write-first and lets rvalid
    // reflect a reservation or write landing on the same edge.
    always_comb begin
        regs_nxt = regs;
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (ZERO_EN && (i == 0)) begin
                // Hardwired zero register: never written, never pending,
                // so even the write-first bypass returns zero.
                regs_nxt[i] = '0;
                busy_nxt[i] = 1'b0;
            end else begin
                // Port B has priority on an address collision.
                if (hit_b[i]) begin
                    regs_nxt[i] = wdata_b;
                end else if (hit_a[i]) begin
                    regs_nxt[i] = wdata_a;
                end
                // A new reservation beats a write retiring the old producer.
                if (hit_rsv[i]) begin
                    busy_nxt[i] = 1'b1;
                end else if (hit_a[i] || hit_b[i]) begin
                    busy_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            rdata_1  <= '0;
            rdata_2  <= '0;
            rvalid_1 <= 1'b1;
            rvalid_2 <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= regs_nxt[i];
            end
            busy     <= busy_nxt;
            rdata_1  <= regs_nxt[raddr_1];
            rdata_2  <= regs_nxt[raddr_2];
            rvalid_1 <= ~busy_nxt[raddr_1];
            rvalid_2 <= ~busy_nxt[raddr_2];
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
//
// Drives two instances of register_file_mp from the same stimulus: one with
// ZERO_REG=0 and one with ZERO_REG=1. A behavioural model (plain arrays,
// writes applied A then B so B naturally wins) predicts every output after
// each clock edge.
// ---------------------------------------------------------------------------
module tb_register_file_mp;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic we_a, we_b, rsv_en;
  logic [ADDR_W-1:0] waddr_a, waddr_b, raddr_1, raddr_2, rsv_addr;
  logic [DATA_W-1:0] wdata_a, wdata_b;

  logic [DATA_W-1:0] rdata_1, rdata_2, rdata_1_z, rdata_2_z;
  logic              rvalid_1, rvalid_2, rvalid_1_z, rvalid_2_z;
  logic [DEPTH-1:0]  busy, busy_z;

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst(rst),
    .we_a(we_a), .we_b(we_b),
    .waddr_a(waddr_a), .waddr_b(waddr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .raddr_1(raddr_1), .raddr_2(raddr_2),
    .rdata_1(rdata_1), .rdata_2(rdata_2),
    .rvalid_1(rvalid_1), .rvalid_2(rvalid_2),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy(busy)
  );

  register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst),
    .we_a(we_a), .we_b(we_b),
    .waddr_a(waddr_a), .waddr_b(waddr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .raddr_1(raddr_1), .raddr_2(raddr_2),
    .rdata_1(rdata_1_z), .rdata_2(rdata_2_z),
    .rvalid_1(rvalid_1_z), .rvalid_2(rvalid_2_z),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy(busy_z)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_mem  [2][DEPTH];
  logic [DEPTH-1:0]  m_busy [2];
  logic              e_rv1  [2];
  logic              e_rv2  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour for both configurations.
  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) m_mem[z][i] = '0;
        m_busy[z] = '0;
        exp_q.push_back('0);
        exp_q.push_back('0);
        e_rv1[z] = 1'b1;
        e_rv2[z] = 1'b1;
      end else begin
        if (we_a && !(z == 1 && waddr_a == 0)) begin
          m_mem[z][waddr_a]  = wdata_a;
          m_busy[z][waddr_a] = 1'b0;
        end
        if (we_b && !(z == 1 && waddr_b == 0)) begin
          m_mem[z][waddr_b]  = wdata_b;
          m_busy[z][waddr_b] = 1'b0;
        end
        if (rsv_en && !(z == 1 && rsv_addr == 0))
          m_busy[z][rsv_addr] = 1'b1;
        exp_q.push_back(m_mem[z][raddr_1]);
        exp_q.push_back(m_mem[z][raddr_2]);
        e_rv1[z] = !m_busy[z][raddr_1];
        e_rv2[z] = !m_busy[z][raddr_2];
      end
    end
  endtask

  task automatic compare();
    logic [DATA_W-1:0] e;
    e = exp_q.pop_front(); check("rdata_1",   rdata_1,   e);
    e = exp_q.pop_front(); check("rdata_2",   rdata_2,   e);
    check("rvalid_1", rvalid_1, e_rv1[0]);
    check("rvalid_2", rvalid_2, e_rv2[0]);
    check("busy",     busy,     m_busy[0]);
    e = exp_q.pop_front(); check("z_rdata_1", rdata_1_z, e);
    e = exp_q.pop_front(); check("z_rdata_2", rdata_2_z, e);
    check("z_rvalid_1", rvalid_1_z, e_rv1[1]);
    check("z_rvalid_2", rvalid_2_z, e_rv2[1]);
    check("z_busy",     busy_z,     m_busy[1]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    we_a = 0; we_b = 0; rsv_en = 0;
    waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0;
    rsv_addr = 0;
  endtask

  // Inputs are set by the caller (at least #1 after the previous edge);
  // the model consumes them at the edge and outputs are checked #1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic random_inputs();
    bit narrow;
    narrow   = ($urandom_range(0, 3) == 0);
    rst      = ($urandom_range(0, 63) != 0);
    we_a     = $urandom_range(0, 1);
    we_b     = $urandom_range(0, 1);
    rsv_en   = ($urandom_range(0, 2) == 0);
    waddr_a  = narrow ? ADDR_W'($urandom_range(0, 2)) : ADDR_W'($urandom_range(0, 15));
    waddr_b  = narrow ? ADDR_W'($urandom_range(0, 2)) : ADDR_W'($urandom_range(0, 15));
    rsv_addr = narrow ? ADDR_W'($urandom_range(0, 2)) : ADDR_W'($urandom_range(0, 15));
    raddr_1  = narrow ? ADDR_W'($urandom_range(0, 2)) : ADDR_W'($urandom_range(0, 15));
    raddr_2  = ($urandom_range(0, 3) == 0) ? raddr_1 : ADDR_W'($urandom_range(0, 15));
    wdata_a  = DATA_W'($urandom);
    wdata_b  = DATA_W'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < DEPTH; i++) m_mem[z][i] = '0;
      m_busy[z] = '0;
      e_rv1[z] = 1'b1;
      e_rv2[z] = 1'b1;
    end
    idle_inputs();
    raddr_1 = 0; raddr_2 = 0;
    rst = 0;
    #1;
    step();
    step();
    rst = 1;

    // Reset state: every address on both ports reads zero and valid.
    for (int a = 0; a < DEPTH; a++) begin
      raddr_1 = ADDR_W'(a);
      raddr_2 = ADDR_W'(DEPTH - 1 - a);
      step();
      check("reset_rd1", rdata_1, 0);
      check("reset_rv1", rvalid_1, 1);
      check("reset_busy", busy, 0);
    end

    // Two writes on different ports in one cycle, read back next cycle.
    we_a = 1; waddr_a = 3; wdata_a = 16'h1234;
    we_b = 1; waddr_b = 5; wdata_b = 16'hBEEF;
    step();
    idle_inputs();
    raddr_1 = 3; raddr_2 = 5;
    step();
    check("dual_wr_rd1", rdata_1, 16'h1234);
    check("dual_wr_rd2", rdata_2, 16'hBEEF);

    // Same-address collision: B wins, visible via bypass and afterwards.
    we_a = 1; waddr_a = 7; wdata_a = 16'h1111;
    we_b = 1; waddr_b = 7; wdata_b = 16'h2222;
    raddr_1 = 7;
    step();
    check("collide_bypass", rdata_1, 16'h2222);
    idle_inputs();
    step();
    check("collide_after", rdata_1, 16'h2222);

    // Reservation lifecycle on register 9.
    rsv_en = 1; rsv_addr = 9; raddr_1 = 9;
    step();
    check("rsv_busy9", busy[9], 1);
    check("rsv_rvalid", rvalid_1, 0);
    idle_inputs();
    we_a = 1; waddr_a = 9; wdata_a = 16'h00AA;
    step();
    check("wr_clr_busy9", busy[9], 0);
    check("wr_clr_rdata", rdata_1, 16'h00AA);
    check("wr_clr_rvalid", rvalid_1, 1);
    rsv_en = 1; rsv_addr = 9;
    we_a = 1; waddr_a = 9; wdata_a = 16'h0055;
    step();
    check("rsv_wr_busy9", busy[9], 1);
    check("rsv_wr_rvalid", rvalid_1, 0);
    idle_inputs();

    // Zero register: write and reserve register 0 on the ZERO_REG=1 copy.
    we_a = 1; waddr_a = 0; wdata_a = 16'hFFFF;
    rsv_en = 1; rsv_addr = 0; raddr_1 = 0;
    step();
    check("zero_rdata", rdata_1_z, 0);
    check("zero_rvalid", rvalid_1_z, 1);
    check("zero_busy0", busy_z[0], 0);
    idle_inputs();
    step();
    check("zero_rdata_after", rdata_1_z, 0);

    // Mid-operation reset discards data and reservations, ignores inputs.
    we_a = 1; waddr_a = 2; wdata_a = 16'h5A5A;
    rsv_en = 1; rsv_addr = 4;
    step();
    rst = 0;
    we_a = 1; waddr_a = 6; wdata_a = 16'h7777;
    rsv_en = 1; rsv_addr = 8;
    step();
    check("rst_busy", busy, 0);
    rst = 1;
    idle_inputs();
    raddr_1 = 2; raddr_2 = 6;
    step();
    check("post_rst_rd2", rdata_1, 0);
    check("post_rst_rd6", rdata_2, 0);
    check("post_rst_busy", busy, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      step();
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; depth is 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 0; when 1, register 0 always reads 0 and ignores writes and reservations.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have ports we_a, we_b  input  1 each  write enables for write ports A and B.
REQ-007 The block SHALL have ports waddr_a, waddr_b  input  ADDR_W each  write addresses.
REQ-008 The block SHALL have ports wdata_a, wdata_b  input  DATA_W each  write data.
REQ-009 The block SHALL have ports raddr_1, raddr_2  input  ADDR_W each  read addresses.
REQ-010 The block SHALL have ports rdata_1, rdata_2  output  DATA_W each  registered read data.
REQ-011 The block SHALL have ports rvalid_1, rvalid_2  output  1 each  high when the returned register is not pending.
REQ-012 The block SHALL have port rsv_en  input  1  reserve request (marks a register pending).
REQ-013 The block SHALL have port rsv_addr  input  ADDR_W  register to reserve.
REQ-014 The block SHALL have port busy  output  2**ADDR_W  per-register pending bits, bit i for register i.

Function
REQ-015 Writes SHALL commit at the rising clk edge when the port's we is high and rst is high.
REQ-016 If we_a and we_b are both high with equal addresses, port B data SHALL be stored; port A is dropped.
REQ-017 Reads SHALL have 1-cycle latency: rdata_n after edge k holds register raddr_n as sampled at edge k.
REQ-018 Reads SHALL be write-first: if a write to raddr_n commits at edge k, rdata_n after edge k SHALL equal that write data (port B priority per REQ-016).
REQ-019 Both read ports SHALL be independent; equal read addresses SHALL return identical data and valid.
REQ-020 rsv_en high at edge k SHALL set busy[rsv_addr] after edge k.
REQ-021 A committed write to register i SHALL clear busy[i] at the same edge.
REQ-022 Reservation and write to the same register at the same edge SHALL leave busy[i] set (new producer wins).
REQ-023 Reserving an already-pending register SHALL keep it pending; writing a non-pending register SHALL leave it non-pending.
REQ-024 rvalid_n after edge k SHALL equal the inverse of busy[raddr_n] as updated by edge k.
REQ-025 With ZERO_REG=1, register 0 SHALL read 0 with rvalid high; busy[0] SHALL remain 0; writes and reservations to 0 SHALL have no effect, including via bypass.
REQ-026 Address arithmetic SHALL be exactly ADDR_W bits; no out-of-range addresses exist.

Reset
REQ-027 rst low at an edge SHALL clear all registers to 0, all busy bits to 0, rdata_1/rdata_2 to 0, rvalid_1/rvalid_2 to 1.
REQ-028 Writes and reservations presented during a reset edge SHALL be ignored.
REQ-029 Reset asserted mid-operation SHALL discard all pending state within that one edge; the first post-reset edge SHALL behave as from power-up.

Verification
REQ-030 Reset then read all 16 addresses on both ports -> every rdata = 0x0000, rvalid = 1, busy = 0x0000.
REQ-031 Write A reg 3=0x1234 and B reg 5=0xBEEF in one cycle, read 3 and 5 next cycle -> rdata_1=0x1234, rdata_2=0xBEEF.
REQ-032 we_a and we_b both to reg 7 (A=0x1111, B=0x2222) with raddr_1=7 same edge -> rdata_1=0x2222 immediately and thereafter.
REQ-033 Reserve reg 9 -> busy[9]=1, read of 9 gives rvalid=0; write 9=0x00AA -> busy[9]=0, read gives 0x00AA rvalid=1; reserve+write 9 same edge -> busy[9]=1.
REQ-034 ZERO_REG=1: write reg 0=0xFFFF and reserve 0 -> rdata=0x0000, rvalid=1, busy[0]=0.
REQ-035 Write reg 2=0x5A5A, reserve reg 4, assert rst for one edge -> reg 2 reads 0x0000, busy=0x0000.
